// File: rtl/mem_port_req.sv
// mem_port_req: processor-side initiator for one port of the shared scratchpad.
// Takes single-beat write and multi-beat burst-read commands from a processing
// element. It drives the request/grant interface of the shared memory and
// returns read beats to the PE in order, with no backpressure.
module mem_port_req #(
    parameter int BUS_SIZE   = 160,
    parameter int UNIT_SIZE  = 32,
    parameter int ADDR_SIZE  = 24,
    parameter int LEN_W      = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    // command side (processing element)
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic                 i_cmd_we,
    input  logic [ADDR_SIZE-1:0] i_cmd_addr,
    input  logic [LEN_W-1:0]     i_cmd_len,
    input  logic [BUS_SIZE-1:0]  i_cmd_wdata,
    input  logic [2:0]           i_cmd_size,
    // shared memory port
    output logic                 o_req_rd,
    output logic                 o_req_wr,
    input  logic                 i_grant_rd,
    input  logic                 i_grant_wr,
    output logic [ADDR_SIZE-1:0] o_addr,
    output logic [BUS_SIZE-1:0]  o_wr_data,
    output logic [2:0]           o_wr_size,
    output logic                 o_wr_en,
    input  logic [BUS_SIZE-1:0]  i_rd_data,
    // response side (processing element)
    output logic                 o_rsp_valid,
    output logic [BUS_SIZE-1:0]  o_rsp_data,
    output logic                 o_rsp_last,
    output logic                 o_wr_done,
    output logic                 o_busy
);

    // Units per beat; the burst address advances by this much per issued beat.
    localparam int                   BLK      = BUS_SIZE / UNIT_SIZE;
    localparam logic [ADDR_SIZE-1:0] BLK_STEP = ADDR_SIZE'(BLK);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_REQ = 2'd1,
        WR_REQ = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    rst_done_q, rst_done_d;
    logic [ADDR_SIZE-1:0]    addr_q, addr_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        beat_q, beat_d;
    logic [BUS_SIZE-1:0]     wdata_q, wdata_d;
    logic [2:0]              size_q, size_d;
    logic [RD_LATENCY-1:0]   pipe_vld_q, pipe_vld_d;
    logic [RD_LATENCY-1:0]   pipe_last_q, pipe_last_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_last_q, rsp_last_d;
    logic [BUS_SIZE-1:0]     rsp_data_q, rsp_data_d;
    logic                    wr_done_q, wr_done_d;

    logic                    in_rd_req;
    logic                    in_wr_req;
    logic                    cmd_accept;
    logic                    rd_issue;
    logic                    wr_issue;
    logic                    pipe_exit;

    // Request qualifiers: grants only count while the matching request is up.
    always_comb begin
        in_rd_req  = (state_q == RD_REQ);
        in_wr_req  = (state_q == WR_REQ);
        cmd_accept = (state_q == IDLE) && rst_done_q && i_cmd_valid;
        rd_issue   = in_rd_req && i_grant_rd;
        wr_issue   = in_wr_req && i_grant_wr;
        pipe_exit  = pipe_vld_q[RD_LATENCY-1];
    end

    // Read tag pipeline: one tag per granted read cycle, carrying the last-beat flag.
    always_comb begin
        pipe_vld_d     = '0;
        pipe_last_d    = '0;
        pipe_vld_d[0]  = rd_issue;
        pipe_last_d[0] = rd_issue && (beat_q == len_q);
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_last_d[i] = pipe_last_q[i-1];
        end
    end

    // Response capture: read data is registered when its tag leaves the pipeline.
    always_comb begin
        rsp_valid_d = 1'b0;
        rsp_last_d  = 1'b0;
        rsp_data_d  = rsp_data_q;
        if (pipe_exit) begin
            rsp_valid_d = 1'b1;
            rsp_last_d  = pipe_last_q[RD_LATENCY-1];
            rsp_data_d  = i_rd_data;
        end
    end

    // Control FSM next-state: command capture, beat issue and drain tracking.
    always_comb begin
        state_d    = state_q;
        rst_done_d = 1'b1;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_d     = beat_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        wr_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    addr_d  = i_cmd_addr;
                    len_d   = i_cmd_len;
                    wdata_d = i_cmd_wdata;
                    size_d  = i_cmd_size;
                    beat_d  = '0;
                    state_d = i_cmd_we ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                if (wr_issue) begin
                    wr_done_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            RD_REQ: begin
                if (rd_issue) begin
                    addr_d = addr_q + BLK_STEP;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave once every outstanding tag has been captured into the response register.
                if (pipe_vld_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops everything in flight immediately.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= IDLE;
            rst_done_q  <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= '0;
            wr_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_done_q  <= rst_done_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_last_q <= pipe_last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_data_q  <= rsp_data_d;
            wr_done_q   <= wr_done_d;
        end
    end

    // Port outputs decode from the state register, so requests fall with reset.
    always_comb begin
        o_cmd_ready = rst_done_q && (state_q == IDLE);
        o_req_rd    = in_rd_req;
        o_req_wr    = in_wr_req;
        o_wr_en     = in_wr_req;
        o_addr      = (in_rd_req || in_wr_req) ? addr_q : '0;
        o_wr_data   = in_wr_req ? wdata_q : '0;
        o_wr_size   = in_wr_req ? size_q : 3'd0;
        o_rsp_valid = rsp_valid_q;
        o_rsp_data  = rsp_data_q;
        o_rsp_last  = rsp_last_q;
        o_wr_done   = wr_done_q;
        o_busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_mem_port_req.sv
// tb_mem_port_req: directed bench for mem_port_req with hand-derived expectations.
// The bench acts as the arbiter (grants) and as the memory (read data per cycle).
module tb_mem_port_req;

   localparam int BUS_SIZE = 160;
   localparam int ADDR_SIZE = 24;
   localparam int LEN_W = 4;

   logic                 i_clk;
   logic                 i_rstn;
   logic                 i_cmd_valid;
   logic                 o_cmd_ready;
   logic                 i_cmd_we;
   logic [ADDR_SIZE-1:0] i_cmd_addr;
   logic [LEN_W-1:0]     i_cmd_len;
   logic [BUS_SIZE-1:0]  i_cmd_wdata;
   logic [2:0]           i_cmd_size;
   logic                 o_req_rd;
   logic                 o_req_wr;
   logic                 i_grant_rd;
   logic                 i_grant_wr;
   logic [ADDR_SIZE-1:0] o_addr;
   logic [BUS_SIZE-1:0]  o_wr_data;
   logic [2:0]           o_wr_size;
   logic                 o_wr_en;
   logic [BUS_SIZE-1:0]  i_rd_data;
   logic                 o_rsp_valid;
   logic [BUS_SIZE-1:0]  o_rsp_data;
   logic                 o_rsp_last;
   logic                 o_wr_done;
   logic                 o_busy;

   int vectors = 0;
   int miscompares = 0;

   mem_port_req #(
      .BUS_SIZE(BUS_SIZE), .UNIT_SIZE(32), .ADDR_SIZE(ADDR_SIZE), .LEN_W(LEN_W), .RD_LATENCY(1)
   ) dut (
      .i_clk(i_clk), .i_rstn(i_rstn),
      .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_we(i_cmd_we),
      .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len), .i_cmd_wdata(i_cmd_wdata),
      .i_cmd_size(i_cmd_size),
      .o_req_rd(o_req_rd), .o_req_wr(o_req_wr), .i_grant_rd(i_grant_rd), .i_grant_wr(i_grant_wr),
      .o_addr(o_addr), .o_wr_data(o_wr_data), .o_wr_size(o_wr_size), .o_wr_en(o_wr_en),
      .i_rd_data(i_rd_data),
      .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_last(o_rsp_last),
      .o_wr_done(o_wr_done), .o_busy(o_busy)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Watchdog so a stuck design still ends the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Count one comparison and report it if observed differs from expected.
   task automatic checkOutput(input string tag, input logic [BUS_SIZE-1:0] observed,
                              input logic [BUS_SIZE-1:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Present a command on the PE side.
   task automatic applyStimulus(input logic valid, input logic we, input logic [ADDR_SIZE-1:0] addr,
                                input logic [LEN_W-1:0] len, input logic [BUS_SIZE-1:0] wdata,
                                input logic [2:0] size);
      i_cmd_valid = valid;
      i_cmd_we    = we;
      i_cmd_addr  = addr;
      i_cmd_len   = len;
      i_cmd_wdata = wdata;
      i_cmd_size  = size;
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Memory read-bus pattern, unique per test and cycle.
   function automatic logic [BUS_SIZE-1:0] pat(input int t, input int k);
      logic [31:0] w;
      w = {t[7:0], 8'h5A, k[15:0]};
      return {5{w}};
   endfunction

   // Run a burst read with a per-cycle grant pattern (bit k-1 = grant in cycle k);
   // the expected addresses and responses come from a small beat model.
   // With chainWrite, a write to 0x30 is offered as soon as the port reports ready.
   task automatic runRead(input int tid, input logic [ADDR_SIZE-1:0] base, input logic [LEN_W-1:0] len,
                          input logic [15:0] gpat, input int ncyc, input bit chainWrite);
      int beats;
      bit issued[32];
      int issueBeat[32];
      bit expReq;
      bit expRsp;
      bit wrSent;
      int acceptK;
      logic [ADDR_SIZE-1:0] expAddr;
      beats = 0;
      wrSent = 0;
      acceptK = 0;
      for (int i = 0; i < 32; i++) begin
         issued[i] = 0;
         issueBeat[i] = 0;
      end
      applyStimulus(1'b1, 1'b0, base, len, '0, 3'd0);
      @(negedge i_clk);
      checkOutput("rd_cmd_ready", o_cmd_ready, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0, '0, 3'd0);
      for (int k = 1; k <= ncyc; k++) begin
         i_grant_rd = gpat[k-1];
         i_rd_data  = pat(tid, k);
         if (i_cmd_valid) i_cmd_valid = 1'b0;
         if (chainWrite && !wrSent && o_cmd_ready) begin
            applyStimulus(1'b1, 1'b1, 24'h000030, '0, {20{8'h3C}}, 3'd2);
            wrSent = 1;
            acceptK = k;
         end
         @(negedge i_clk);
         expReq = (beats <= int'(len));
         checkOutput("rd_req", o_req_rd, expReq);
         checkOutput("req_excl", o_req_rd & o_req_wr, 1'b0);
         if (expReq) begin
            expAddr = base + ADDR_SIZE'(beats * 5);
            checkOutput("rd_addr", o_addr, expAddr);
         end
         expRsp = (k >= 3) && issued[k-2];
         checkOutput("rsp_valid", o_rsp_valid, expRsp);
         if (expRsp) begin
            checkOutput("rsp_data", o_rsp_data, pat(tid, k-1));
            checkOutput("rsp_last", o_rsp_last, issueBeat[k-2] == int'(len));
         end
         if (wrSent && k == acceptK + 1) checkOutput("seq_wr_req", o_req_wr, 1'b1);
         if (expReq && gpat[k-1]) begin
            issued[k] = 1;
            issueBeat[k] = beats;
            beats++;
         end
         tick();
      end
      i_grant_rd = 1'b0;
      i_cmd_valid = 1'b0;
      if (chainWrite) checkOutput("seq_accept_early", (wrSent && acceptK <= 5), 1'b1);
   endtask

   initial begin
      i_rstn = 1'b0;
      i_grant_rd = 1'b0;
      i_grant_wr = 1'b0;
      i_rd_data = '0;
      applyStimulus(1'b0, 1'b0, '0, '0, '0, 3'd0);

      // Reset values while reset is held.
      #2;
      checkOutput("rst_ready", o_cmd_ready, 1'b0);
      checkOutput("rst_busy", o_busy, 1'b0);
      checkOutput("rst_req_rd", o_req_rd, 1'b0);
      checkOutput("rst_req_wr", o_req_wr, 1'b0);
      checkOutput("rst_rsp_valid", o_rsp_valid, 1'b0);
      checkOutput("rst_wr_done", o_wr_done, 1'b0);
      @(posedge i_clk);
      @(posedge i_clk);
      #3 i_rstn = 1'b1;
      tick();
      @(negedge i_clk);
      checkOutput("rst_ready_after", o_cmd_ready, 1'b1);
      tick();

      // Single write, grant two cycles after the request.
      $display("[TB] single write");
      applyStimulus(1'b1, 1'b1, 24'h000010, 4'd0, {20{8'hA5}}, 3'd5);
      @(negedge i_clk);
      checkOutput("wr_cmd_ready", o_cmd_ready, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0, '0, 3'd0);
      @(negedge i_clk);
      checkOutput("wr_req", o_req_wr, 1'b1);
      checkOutput("wr_req_rd_low", o_req_rd, 1'b0);
      checkOutput("wr_en_c1", o_wr_en, 1'b1);
      checkOutput("wr_data", o_wr_data, {20{8'hA5}});
      checkOutput("wr_size", o_wr_size, 3'd5);
      checkOutput("wr_busy", o_busy, 1'b1);
      checkOutput("wr_ready_low", o_cmd_ready, 1'b0);
      tick();
      @(negedge i_clk);
      checkOutput("wr_done_c2", o_wr_done, 1'b0);
      tick();
      i_grant_wr = 1'b1;
      @(negedge i_clk);
      checkOutput("wr_en_grant", o_wr_en, 1'b1);
      checkOutput("wr_addr_grant", o_addr, 24'h000010);
      checkOutput("wr_done_c3", o_wr_done, 1'b0);
      tick();
      i_grant_wr = 1'b0;
      @(negedge i_clk);
      checkOutput("wr_done_pulse", o_wr_done, 1'b1);
      checkOutput("wr_en_after", o_wr_en, 1'b0);
      checkOutput("wr_req_after", o_req_wr, 1'b0);
      checkOutput("wr_busy_after", o_busy, 1'b0);
      tick();
      @(negedge i_clk);
      checkOutput("wr_done_once", o_wr_done, 1'b0);
      tick();

      // Burst read len=3 at 0x20 with grant held two extra cycles (stale grants).
      $display("[TB] burst read continuous grant");
      runRead(1, 24'h000020, 4'd3, 16'b0000_0000_0011_1111, 8, 1'b0);

      // Write grant while idle must not cause a write.
      $display("[TB] stale write grant");
      i_grant_wr = 1'b1;
      @(negedge i_clk);
      checkOutput("stale_wr_en", o_wr_en, 1'b0);
      checkOutput("stale_req_wr", o_req_wr, 1'b0);
      tick();
      @(negedge i_clk);
      checkOutput("stale_wr_en2", o_wr_en, 1'b0);
      tick();
      i_grant_wr = 1'b0;
      @(negedge i_clk);
      checkOutput("stale_wr_done", o_wr_done, 1'b0);
      checkOutput("stale_busy", o_busy, 1'b0);
      tick();

      // Burst read len=2 with gapped grants 1,0,0,1,0,1.
      $display("[TB] burst read gapped grant");
      runRead(2, 24'h000040, 4'd2, 16'b0000_0000_0010_1001, 10, 1'b0);

      // Address wrap, then a write offered in the first idle cycle.
      $display("[TB] wrap and sequencing");
      runRead(3, 24'hFFFFFE, 4'd1, 16'b0000_0000_0000_0011, 6, 1'b1);
      i_grant_wr = 1'b1;
      @(negedge i_clk);
      checkOutput("seq_wr_en", o_wr_en, 1'b1);
      checkOutput("seq_addr", o_addr, 24'h000030);
      checkOutput("seq_excl", o_req_rd & o_req_wr, 1'b0);
      tick();
      i_grant_wr = 1'b0;
      @(negedge i_clk);
      checkOutput("seq_wr_done", o_wr_done, 1'b1);
      tick();

      // Reset in the middle of a read with beats outstanding.
      $display("[TB] reset mid read");
      applyStimulus(1'b1, 1'b0, 24'h000060, 4'd3, '0, 3'd0);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0, '0, 3'd0);
      i_grant_rd = 1'b1;
      tick();
      tick();
      i_grant_rd = 1'b0;
      i_rstn = 1'b0;
      #1;
      checkOutput("mid_rst_req_rd", o_req_rd, 1'b0);
      checkOutput("mid_rst_rsp_valid", o_rsp_valid, 1'b0);
      checkOutput("mid_rst_busy", o_busy, 1'b0);
      checkOutput("mid_rst_ready", o_cmd_ready, 1'b0);
      checkOutput("mid_rst_addr", o_addr, 24'h000000);
      tick();
      #2 i_rstn = 1'b1;
      @(negedge i_clk);
      checkOutput("post_rst_rsp0", o_rsp_valid, 1'b0);
      tick();
      @(negedge i_clk);
      checkOutput("post_rst_ready", o_cmd_ready, 1'b1);
      checkOutput("post_rst_rsp1", o_rsp_valid, 1'b0);
      checkOutput("post_rst_busy", o_busy, 1'b0);
      tick();
      @(negedge i_clk);
      checkOutput("post_rst_rsp2", o_rsp_valid, 1'b0);
      checkOutput("post_rst_req_rd", o_req_rd, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
